rng_ctrl: RTL and testbench
===========================

// Module: rng_ctrl
// PURPOSE
//   Bus-mapped controller for the 8-bit Fibonacci LFSR random source (feedback q[7]^q[5]).
//   Owns the LFSR state and sequences it: seeding, stepping N shifts per consumed value,
//   optional free-run, plus a ready/overrun status. Sits on the CPU peripheral bus.
//   The CPU reads fresh bytes from it instead of sampling a raw free-running LFSR.
// PARAMETERS
//   STEPS      4     LFSR shifts per consumed value (1..15); whitens consecutive reads
//   SEED_RST   8'h01 LFSR value loaded at reset
// PORTS
//   clk     in   1  system clock; all logic on posedge
//   rst     in   1  reset, synchronous, active-high
//   cs      in   1  chip select, one-cycle strobe per bus access
//   rw      in   1  1 = read, 0 = write (qualified by cs)
//   addr    in   2  register select: 0 DATA, 1 CTRL, 2 SEED, 3 STATUS
//   din     in   8  write data
//   dout    out  8  read data, combinational from addr (0x00 when cs=0)
//   ready   out  1  a fresh value is available in DATA (mirrors STATUS[0])
// BEHAVIOUR
//   Reset: lfsr=SEED_RST, ctrl=0x00, overrun=0, step_cnt=0, state=READY, ready=1, dout=0.
//   LFSR step: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]}; exactly one step per clk when stepping.
//   Registers:
//     DATA   rd: current lfsr. If state=READY, start a STEP burst next cycle.
//            wr: ignored.
//     CTRL   rd/wr: bit0 FREERUN, bit1 HOLD; bits 7:2 read 0.
//     SEED   wr: lfsr<=din (0x00 is replaced by 0x01), step_cnt=0, state=READY, overrun=0.
//            rd: 0x00.
//     STATUS rd: {6'b0, overrun, ready}; a STATUS read clears overrun (value returned is pre-clear).
//   FSM:
//     READY: ready=1; DATA read -> STEP with step_cnt=STEPS.
//            FREERUN=1 and HOLD=0 -> lfsr steps every clk while in READY.
//     STEP:  ready=0; each clk lfsr steps, step_cnt--.
//            Cycle where step_cnt reaches 0 is the last step; READY on the following clk.
//            Burst latency = STEPS clks from the cycle after the DATA read.
//            HOLD=1 freezes lfsr and step_cnt (state stays STEP).
//     HOLD=1 never blocks bus access.
//   Boundary cases:
//     DATA read while STEP: returns current (partial) lfsr, sets overrun=1, does not restart burst.
//     SEED write in same cycle as a step: seed wins. SEED write during STEP aborts the burst.
//     CTRL write during STEP: takes effect next clk; clearing FREERUN does not abort a burst.
//     rst asserted mid-burst: all state returns to reset values on that edge.
//     The LFSR never holds 0x00: the seed guard applies and the step function keeps nonzero states nonzero.
// TESTING
//   1 Reset: rst 2 clks; read STATUS -> 0x01, DATA -> 0x01, CTRL -> 0x00.
//   2 STEPS=4, seed 0x01: read DATA -> 0x01.
//     ready low 4 clks; then DATA -> 0x10; next burst; then DATA -> 0x05.
//   3 Overrun: read DATA, read DATA again 1 clk later -> 2nd read partial;
//     STATUS -> 0x02 (ready=0); after burst STATUS -> 0x01.
//   4 Seed guard: write SEED 0x00 -> DATA reads 0x01. Write SEED 0x41 mid-burst -> burst aborted, ready=1, DATA 0x41.
//   5 Freerun: CTRL=0x01 from seed 0x01; 6 clks later DATA = 0x41.
//     CTRL=0x03 -> DATA constant over 10 clks.
//   6 rst asserted mid-burst -> next cycle ready=1, DATA 0x01, overrun 0, CTRL 0x00.

Source files
------------

// File: rtl/rng_ctrl.sv
// rng_ctrl: bus-mapped sequencer for an 8-bit Fibonacci LFSR (taps q[7]^q[5]).
// Each consumed DATA read triggers a whitening burst of STEPS shifts; optional free-run.
module rng_ctrl #(
   parameter int unsigned STEPS    = 4,
   parameter logic [7:0]  SEED_RST = 8'h01
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs,
   input  logic       rw,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       ready
);

   localparam int unsigned CNT_W = 4;
   localparam logic [1:0]  A_DATA   = 2'd0;
   localparam logic [1:0]  A_CTRL   = 2'd1;
   localparam logic [1:0]  A_SEED   = 2'd2;
   localparam logic [1:0]  A_STATUS = 2'd3;

   typedef enum logic {ST_READY = 1'b0, ST_STEP = 1'b1} state_t;

   state_t           r_state;
   logic [7:0]       r_lfsr;
   logic [1:0]       r_ctrl;
   logic             r_overrun;
   logic             r_ready;
   logic [CNT_W-1:0] r_step_cnt;

   logic [7:0] w_lfsr_next;
   logic       w_rd_data;
   logic       w_rd_status;
   logic       w_wr_ctrl;
   logic       w_wr_seed;
   logic       w_freerun;
   logic       w_hold;
   logic [7:0] w_seed;
   logic [7:0] w_dout;

   // Bus decode and LFSR next-state function
   assign w_rd_data   = cs &  rw & (addr == A_DATA);
   assign w_rd_status = cs &  rw & (addr == A_STATUS);
   assign w_wr_ctrl   = cs & ~rw & (addr == A_CTRL);
   assign w_wr_seed   = cs & ~rw & (addr == A_SEED);
   assign w_freerun   = r_ctrl[0];
   assign w_hold      = r_ctrl[1];
   assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5]};
   // A zero seed would lock the LFSR, so it is replaced by 0x01
   assign w_seed      = (din == 8'h00) ? 8'h01 : din;

   // Sequencer: seeding, burst stepping, free-run and overrun tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_READY;
         r_lfsr     <= SEED_RST;
         r_ctrl     <= 2'b00;
         r_overrun  <= 1'b0;
         r_ready    <= 1'b1;
         r_step_cnt <= '0;
      end else begin
         if (w_wr_ctrl) begin
            r_ctrl <= din[1:0];
         end
         if (w_wr_seed) begin
            r_lfsr     <= w_seed;
            r_step_cnt <= '0;
            r_state    <= ST_READY;
            r_ready    <= 1'b1;
            r_overrun  <= 1'b0;
         end else begin
            if (w_rd_status) begin
               r_overrun <= 1'b0;
            end
            case (r_state)
               ST_READY: begin
                  if (w_freerun && !w_hold) begin
                     r_lfsr <= w_lfsr_next;
                  end
                  if (w_rd_data) begin
                     r_state    <= ST_STEP;
                     r_ready    <= 1'b0;
                     r_step_cnt <= CNT_W'(STEPS);
                  end
               end
               ST_STEP: begin
                  if (w_rd_data) begin
                     r_overrun <= 1'b1;
                  end
                  if (!w_hold) begin
                     r_lfsr     <= w_lfsr_next;
                     r_step_cnt <= r_step_cnt - CNT_W'(1);
                     if (r_step_cnt == CNT_W'(1)) begin
                        r_state <= ST_READY;
                        r_ready <= 1'b1;
                     end
                  end
               end
               default: begin
                  r_state <= ST_READY;
                  r_ready <= 1'b1;
               end
            endcase
         end
      end
   end

   // Read mux, driven only while selected
   always_comb begin
      w_dout = 8'h00;
      if (cs) begin
         case (addr)
            A_DATA:   w_dout = r_lfsr;
            A_CTRL:   w_dout = {6'b0, r_ctrl};
            A_SEED:   w_dout = 8'h00;
            A_STATUS: w_dout = {6'b0, r_overrun, r_ready};
            default:  w_dout = 8'h00;
         endcase
      end
   end

   assign dout  = w_dout;
   assign ready = r_ready;

endmodule

// File: tb/tb_rng_ctrl.sv
// Directed bench for rng_ctrl with hand-computed LFSR values (STEPS=4).
module tb_rng_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cs;
   logic       rw;
   logic [1:0] addr;
   logic [7:0] din;
   logic [7:0] dout;
   logic       ready;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [1:0] A_DATA   = 2'd0;
   localparam logic [1:0] A_CTRL   = 2'd1;
   localparam logic [1:0] A_SEED   = 2'd2;
   localparam logic [1:0] A_STATUS = 2'd3;

   rng_ctrl #(.STEPS(4), .SEED_RST(8'h01)) dut (
      .clk   (clk),
      .rst   (rst),
      .cs    (cs),
      .rw    (rw),
      .addr  (addr),
      .din   (din),
      .dout  (dout),
      .ready (ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
      end
   endtask

   // One-cycle read: drive on negedge, sample combinational dout, release after the edge
   task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string tag);
      @(negedge clk);
      cs = 1'b1; rw = 1'b1; addr = a;
      #1;
      check(tag, dout, exp);
      @(posedge clk);
      #1;
      cs = 1'b0; rw = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; rw = 1'b0; addr = a; din = d;
      @(posedge clk);
      #1;
      cs = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; cs = 1'b0; rw = 1'b0; addr = 2'd0; din = 8'h00;

      // 1: reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_ready", {7'b0, ready}, 8'h01);
      check("rst_dout_idle", dout, 8'h00);
      rd(A_STATUS, 8'h01, "rst_status");
      rd(A_DATA,   8'h01, "rst_data");
      rd(A_CTRL,   8'h00, "rst_ctrl");

      // 2: burst of 4 steps per consumed value
      wr(A_SEED, 8'h01);
      rd(A_DATA, 8'h01, "burst0_data");
      check("burst_ready_e0", {7'b0, ready}, 8'h00);
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("burst_ready_e%0d", i), {7'b0, ready}, 8'h00);
      end
      @(posedge clk); #1;
      check("burst_ready_e4", {7'b0, ready}, 8'h01);
      rd(A_DATA, 8'h10, "burst1_data");
      idle(4);
      rd(A_DATA, 8'h05, "burst2_data");

      // 3: overrun
      wr(A_SEED, 8'h01);
      rd(A_DATA,   8'h01, "ovr_first");
      rd(A_DATA,   8'h01, "ovr_partial");
      rd(A_STATUS, 8'h02, "ovr_status_set");
      idle(4);
      rd(A_STATUS, 8'h01, "ovr_status_clr");
      rd(A_DATA,   8'h10, "ovr_data_after");

      // 4: seed guard and mid-burst seed abort
      wr(A_SEED, 8'h00);
      rd(A_DATA, 8'h01, "seed_zero_guard");
      idle(1);
      wr(A_SEED, 8'h41);
      check("seed_abort_ready", {7'b0, ready}, 8'h01);
      rd(A_DATA,   8'h41, "seed_abort_data");
      rd(A_STATUS, 8'h00, "seed_status_busy");
      idle(4);

      // 5: free-run then hold
      wr(A_SEED, 8'h01);
      wr(A_CTRL, 8'h01);
      idle(6);
      rd(A_DATA, 8'h41, "freerun_6clk");
      wr(A_CTRL, 8'h03);
      rd(A_DATA, 8'h05, "hold_start");
      idle(10);
      rd(A_DATA, 8'h05, "hold_10clk");
      check("hold_ready", {7'b0, ready}, 8'h00);
      rd(A_CTRL, 8'h03, "ctrl_rdback");

      // 6: reset mid-burst
      wr(A_CTRL, 8'h00);
      idle(1);
      check("pre_rst_busy", {7'b0, ready}, 8'h00);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_ready", {7'b0, ready}, 8'h01);
      @(negedge clk);
      rst = 1'b0;
      rd(A_STATUS, 8'h01, "midrst_status");
      rd(A_CTRL,   8'h00, "midrst_ctrl");
      rd(A_DATA,   8'h01, "midrst_data");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
